// File: rtl/cu_fsm.sv
// Multicycle control sequencer for the OTTER core: walks each instruction through
// FETCH/EXEC/(WB), diverts into INTR for pending interrupts and counts retired instructions.
module cu_fsm #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             intr,
    input  logic             mie,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_we2,
    output logic             mem_rden1,
    output logic             mem_rden2,
    output logic             csr_we,
    output logic             int_taken,
    output logic             mret_exec,
    output logic             dp_rst,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_RG3    = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    state_t             r_state;
    state_t             w_next;
    logic               w_intr_sync;
    logic               w_intr_pend;
    logic               w_retire;
    logic [CNT_W-1:0]   r_instret;

    // Synchroniser for the asynchronous interrupt line; zero stages is a straight bypass.
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_intr_sync = intr;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= intr;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end
            assign w_intr_sync = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_intr_pend = w_intr_sync & mie;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_we2   = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        dp_rst    = 1'b0;
        w_retire  = 1'b0;
        w_next    = ST_INIT;
        case (r_state)
            ST_INIT: begin
                dp_rst = 1'b1;
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                w_next    = ST_EXEC;
            end
            ST_EXEC: begin
                if (opcode == OP_LOAD) begin
                    // Loads finish in WB; the interrupt window moves there with them.
                    mem_rden2 = 1'b1;
                    w_next    = ST_WB;
                end else begin
                    pc_write = 1'b1;
                    w_retire = 1'b1;
                    w_next   = w_intr_pend ? ST_INTR : ST_FETCH;
                    case (opcode)
                        OP_STORE: mem_we2 = 1'b1;
                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: reg_write = 1'b1;
                        OP_SYS: begin
                            case (func3)
                                3'b000: mret_exec = 1'b1;
                                3'b001, 3'b010, 3'b011: begin
                                    reg_write = 1'b1;
                                    csr_we    = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                w_retire  = 1'b1;
                w_next    = w_intr_pend ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                w_next    = ST_FETCH;
            end
            default: w_next = ST_INIT;
        endcase
    end

    assign instret   = r_instret;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: default build plus a CNT_W=4 build sharing the same stimulus.
module tb_cu_fsm;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPRG3  = 7'b0110011;
    localparam logic [6:0] SYS    = 7'b1110011;

    // {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, mret_exec, dp_rst}
    localparam logic [8:0] O_INIT  = 9'b000000001;
    localparam logic [8:0] O_FETCH = 9'b000100000;
    localparam logic [8:0] O_ALU   = 9'b110000000;
    localparam logic [8:0] O_LOADX = 9'b000010000;
    localparam logic [8:0] O_WB    = 9'b110000000;
    localparam logic [8:0] O_STORE = 9'b101000000;
    localparam logic [8:0] O_PC    = 9'b100000000;
    localparam logic [8:0] O_MRET  = 9'b100000010;
    localparam logic [8:0] O_CSR   = 9'b110001000;
    localparam logic [8:0] O_INTR  = 9'b100000100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        intr = 1'b0;
    logic        mie = 1'b0;
    logic [6:0]  opcode = OPIMM;
    logic [2:0]  func3 = 3'b000;

    logic        pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, mret_exec, dp_rst;
    logic [31:0] instret;
    logic [2:0]  state_dbg;
    logic        pc_write_b, reg_write_b, mem_we2_b, mem_rden1_b, mem_rden2_b, csr_we_b;
    logic        int_taken_b, mret_exec_b, dp_rst_b;
    logic [3:0]  instret_b;
    logic [2:0]  state_dbg_b;
    logic [8:0]  outs;

    int checks = 0;
    int errors = 0;

    assign outs = {pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we, int_taken, mret_exec, dp_rst};

    cu_fsm #(.SYNC_STAGES(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .intr(intr), .mie(mie), .opcode(opcode), .func3(func3),
        .pc_write(pc_write), .reg_write(reg_write), .mem_we2(mem_we2), .mem_rden1(mem_rden1),
        .mem_rden2(mem_rden2), .csr_we(csr_we), .int_taken(int_taken), .mret_exec(mret_exec),
        .dp_rst(dp_rst), .instret(instret), .state_dbg(state_dbg)
    );

    cu_fsm #(.SYNC_STAGES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .intr(intr), .mie(mie), .opcode(opcode), .func3(func3),
        .pc_write(pc_write_b), .reg_write(reg_write_b), .mem_we2(mem_we2_b), .mem_rden1(mem_rden1_b),
        .mem_rden2(mem_rden2_b), .csr_we(csr_we_b), .int_taken(int_taken_b), .mret_exec(mret_exec_b),
        .dp_rst(dp_rst_b), .instret(instret_b), .state_dbg(state_dbg_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic i, input logic m, input logic [6:0] op, input logic [2:0] f3);
        rst_n  = 1'b0;
        intr   = i;
        mie    = m;
        opcode = op;
        func3  = f3;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset_alu();
        int exp_st[6]  = '{1, 2, 1, 2, 1, 2};
        int exp_cnt[6] = '{0, 0, 1, 1, 2, 2};
        do_reset(1'b0, 1'b0, OPIMM, 3'b000);
        checks++;
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL t1_reset_state got %0d exp 0", state_dbg); end
        checks++;
        if (outs !== O_INIT) begin errors++; $display("FAIL t1_reset_outs got %b exp %b", outs, O_INIT); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL t1_reset_instret got %0d exp 0", instret); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (state_dbg !== 3'(exp_st[k]))
                begin errors++; $display("FAIL t1_state step %0d got %0d exp %0d", k, state_dbg, exp_st[k]); end
            checks++;
            if (outs !== ((exp_st[k] == 1) ? O_FETCH : O_ALU))
                begin errors++; $display("FAIL t1_outs step %0d got %b", k, outs); end
            checks++;
            if (instret !== 32'(exp_cnt[k]))
                begin errors++; $display("FAIL t1_instret step %0d got %0d exp %0d", k, instret, exp_cnt[k]); end
        end
    endtask

    task automatic test_load();
        int         exp_st[7]  = '{1, 2, 3, 1, 2, 3, 1};
        int         exp_cnt[7] = '{0, 0, 0, 1, 1, 1, 2};
        logic [8:0] exp_o[7]   = '{O_FETCH, O_LOADX, O_WB, O_FETCH, O_LOADX, O_WB, O_FETCH};
        do_reset(1'b0, 1'b0, LOAD, 3'b010);
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (state_dbg !== 3'(exp_st[k]))
                begin errors++; $display("FAIL t2_state step %0d got %0d exp %0d", k, state_dbg, exp_st[k]); end
            checks++;
            if (outs !== exp_o[k])
                begin errors++; $display("FAIL t2_outs step %0d got %b exp %b", k, outs, exp_o[k]); end
            checks++;
            if (instret !== 32'(exp_cnt[k]))
                begin errors++; $display("FAIL t2_instret step %0d got %0d exp %0d", k, instret, exp_cnt[k]); end
        end
    endtask

    task automatic test_exec_decode();
        logic [6:0] t_op[13] = '{STORE, BRANCH, LUI, AUIPC, JAL, JALR, OPRG3,
                                 SYS, SYS, SYS, SYS, SYS, 7'b1111111};
        logic [2:0] t_f3[13] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                 3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd0};
        logic [8:0] t_o[13]  = '{O_STORE, O_PC, O_ALU, O_ALU, O_ALU, O_ALU, O_ALU,
                                 O_CSR, O_CSR, O_CSR, O_MRET, O_PC, O_PC};
        do_reset(1'b0, 1'b0, OPIMM, 3'b000);
        step();
        for (int k = 0; k < 13; k++) begin
            opcode = t_op[k];
            func3  = t_f3[k];
            step();
            checks++;
            if (state_dbg !== 3'd2 || outs !== t_o[k])
                begin errors++; $display("FAIL decode entry %0d state %0d outs %b exp state 2 outs %b", k, state_dbg, outs, t_o[k]); end
            step();
        end
        checks++;
        if (instret !== 32'd13) begin errors++; $display("FAIL decode_instret got %0d exp 13", instret); end
    endtask

    task automatic test_interrupt();
        int   exp_st[7]  = '{2, 1, 2, 4, 1, 2, 1};
        int   exp_cnt[7] = '{0, 1, 1, 2, 2, 2, 3};
        logic exp_it[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset(1'b0, 1'b1, OPRG3, 3'b000);
        step();
        intr = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (state_dbg !== 3'(exp_st[k]))
                begin errors++; $display("FAIL t3_state step %0d got %0d exp %0d", k, state_dbg, exp_st[k]); end
            checks++;
            if (int_taken !== exp_it[k])
                begin errors++; $display("FAIL t3_int_taken step %0d got %b exp %b", k, int_taken, exp_it[k]); end
            checks++;
            if (instret !== 32'(exp_cnt[k]))
                begin errors++; $display("FAIL t3_instret step %0d got %0d exp %0d", k, instret, exp_cnt[k]); end
            if (k == 3) begin
                checks++;
                if (outs !== O_INTR) begin errors++; $display("FAIL t3_intr_outs got %b exp %b", outs, O_INTR); end
                intr = 1'b0;
                mie  = 1'b0;
            end
        end
    endtask

    task automatic test_mask_then_load();
        do_reset(1'b1, 1'b0, OPIMM, 3'b000);
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (state_dbg !== ((k % 2 == 0) ? 3'd1 : 3'd2))
                begin errors++; $display("FAIL t4_masked_state step %0d got %0d", k, state_dbg); end
        end
        opcode = LOAD;
        step();
        checks++;
        if (state_dbg !== 3'd2 || outs !== O_LOADX)
            begin errors++; $display("FAIL t4_load_exec state %0d outs %b exp state 2 outs %b", state_dbg, outs, O_LOADX); end
        mie = 1'b1;
        step();
        checks++;
        if (state_dbg !== 3'd3) begin errors++; $display("FAIL t4_wb_state got %0d exp 3", state_dbg); end
        step();
        checks++;
        if (state_dbg !== 3'd4 || int_taken !== 1'b1)
            begin errors++; $display("FAIL t4_intr state %0d int_taken %b exp 4 1", state_dbg, int_taken); end
        intr = 1'b0;
        mie  = 1'b0;
        step();
        checks++;
        if (state_dbg !== 3'd1) begin errors++; $display("FAIL t4_after_intr got %0d exp 1", state_dbg); end
    endtask

    task automatic test_mret_csr();
        do_reset(1'b1, 1'b1, SYS, 3'b000);
        step();
        step();
        checks++;
        if (state_dbg !== 3'd2 || outs !== O_MRET)
            begin errors++; $display("FAIL t5_mret state %0d outs %b exp state 2 outs %b", state_dbg, outs, O_MRET); end
        step();
        checks++;
        if (state_dbg !== 3'd4 || int_taken !== 1'b1)
            begin errors++; $display("FAIL t5_mret_intr state %0d int_taken %b exp 4 1", state_dbg, int_taken); end
        intr = 1'b0;
        mie  = 1'b0;
        step();
        func3 = 3'b011;
        step();
        checks++;
        if (state_dbg !== 3'd2 || outs !== O_CSR)
            begin errors++; $display("FAIL t5_csrrc state %0d outs %b exp state 2 outs %b", state_dbg, outs, O_CSR); end
        step();
        checks++;
        if (instret !== 32'd2) begin errors++; $display("FAIL t5_instret got %0d exp 2", instret); end
    endtask

    task automatic test_reset_mid_wb();
        do_reset(1'b0, 1'b0, LOAD, 3'b000);
        repeat (6) step();
        checks++;
        if (state_dbg !== 3'd3 || reg_write !== 1'b1 || instret !== 32'd1)
            begin errors++; $display("FAIL t6_pre state %0d reg_write %b instret %0d exp 3 1 1", state_dbg, reg_write, instret); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state_dbg !== 3'd0 || instret !== 32'd0)
            begin errors++; $display("FAIL t6_async state %0d instret %0d exp 0 0", state_dbg, instret); end
        checks++;
        if (reg_write !== 1'b0 || dp_rst !== 1'b1)
            begin errors++; $display("FAIL t6_async_outs reg_write %b dp_rst %b exp 0 1", reg_write, dp_rst); end
        @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== 3'd0) begin errors++; $display("FAIL t6_held got %0d exp 0", state_dbg); end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_instret_wrap();
        do_reset(1'b0, 1'b0, OPIMM, 3'b000);
        repeat (31) step();
        checks++;
        if (instret_b !== 4'hF || instret !== 32'd15)
            begin errors++; $display("FAIL wrap_pre narrow %0d wide %0d exp 15 15", instret_b, instret); end
        step();
        step();
        checks++;
        if (instret_b !== 4'h0) begin errors++; $display("FAIL wrap_narrow got %0d exp 0", instret_b); end
        checks++;
        if (instret !== 32'd16) begin errors++; $display("FAIL wrap_wide got %0d exp 16", instret); end
    endtask

    initial begin
        test_reset_alu();
        test_load();
        test_exec_decode();
        test_interrupt();
        test_mask_then_load();
        test_mret_csr();
        test_reset_mid_wb();
        test_instret_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
